// File: rtl/dm_unit_if.sv
// rtl/dm_unit_if.sv - request/response bus between ctrl and the data memory unit
//
// master (ctrl side) : drives mem_req, mem_we, mem_addr[15:0], mem_wdata[31:0]
//                      observes mem_busy, mem_rdy, mem_rdata[31:0], addr_err
// slave  (dm_unit)   : the mirror image of master
interface dm_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_busy;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic        addr_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_busy, mem_rdy, mem_rdata, addr_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_busy, mem_rdy, mem_rdata, addr_err
    );
endinterface

// File: rtl/dm_unit.sv
// rtl/dm_unit.sv - multi-cycle data memory for SISC load/store instructions
//
// Parameters:
//   AW          word-address width of the internal RAM (2**AW x 32-bit words)
//   WAIT_STATES extra cycles between request acceptance and completion (0..15)
// Ports:
//   clk  in  system clock, all state changes on posedge
//   rst  in  synchronous active-high reset; aborts any access in flight
//   bus  dm_unit_if.slave
//        mem_req/mem_we/mem_addr/mem_wdata  request, sampled when the unit is free
//        mem_busy   access in progress
//        mem_rdy    one-cycle completion pulse
//        mem_rdata  last load result, held until the next load completes
//        addr_err   pulses with mem_rdy when the address was out of range
module dm_unit #(
    parameter int AW          = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic     clk,
    input  logic     rst,
    dm_unit_if.slave bus
);
    localparam int         DEPTH = 1 << AW;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        commit;

    logic        op_we;
    logic [15:0] op_addr;
    logic [31:0] op_wdata;
    logic        in_range;
    logic [AW-1:0] idx;

    logic        busy_q;
    logic        rdy_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] ram [DEPTH];

    // Upper address bits must be clear; in-range addresses never alias.
    assign in_range = (op_addr >> AW) == 16'd0;
    assign idx      = op_addr[AW-1:0];

    // DONE is the mem_rdy cycle. A request sampled at the edge that leaves
    // DONE is accepted, so a held mem_req gets one access every
    // WAIT_STATES+2 cycles with mem_busy staying high throughout.
    // WAIT is entered with cnt=WAIT_STATES and counts down; the edge after
    // cnt reaches zero commits, giving rdy at E+WAIT_STATES+1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.mem_req) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = WS;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields only matter after acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_we    <= bus.mem_we;
            op_addr  <= bus.mem_addr;
            op_wdata <= bus.mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            busy_q <= (state_d != IDLE);
            rdy_q  <= commit;
            err_q  <= commit && !in_range;
            if (commit && !op_we) begin
                rdata_q <= in_range ? ram[idx] : 32'h0;
            end
        end
    end

    // RAM is never cleared; reset only blocks a pending store from landing.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_we && in_range) begin
            ram[idx] <= op_wdata;
        end
    end

    assign bus.mem_busy  = busy_q;
    assign bus.mem_rdy   = rdy_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.addr_err  = err_q;
endmodule

// File: tb/tb_dm_unit.sv
// tb/tb_dm_unit.sv - self-checking bench for dm_unit (WAIT_STATES=2 and 0)
module tb_dm_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_unit_if bus_a ();
    dm_unit_if bus_b ();

    dm_unit #(.AW(8), .WAIT_STATES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dm_unit #(.AW(8), .WAIT_STATES(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: one word array per DUT plus the expected held load result.
    logic [31:0] model_ram   [2][256];
    bit          model_known [2][256];
    logic [31:0] model_rdata [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic req, input logic we,
                         input logic [15:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            bus_a.mem_req = req; bus_a.mem_we = we; bus_a.mem_addr = addr; bus_a.mem_wdata = wd;
        end else begin
            bus_b.mem_req = req; bus_b.mem_we = we; bus_b.mem_addr = addr; bus_b.mem_wdata = wd;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? bus_b.mem_busy : bus_a.mem_busy;
    endfunction
    function automatic logic get_rdy(input int sel);
        return (sel != 0) ? bus_b.mem_rdy : bus_a.mem_rdy;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel != 0) ? bus_b.addr_err : bus_a.addr_err;
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        return (sel != 0) ? bus_b.mem_rdata : bus_a.mem_rdata;
    endfunction

    // Apply the expected effect of one completed access to the model.
    task automatic model_apply(input int sel, input logic we, input logic [15:0] addr,
                               input logic [31:0] wd);
        bit in_r;
        in_r = (addr < 16'd256);
        if (!we) begin
            model_rdata[sel] = in_r ? model_ram[sel][addr[7:0]] : 32'h0;
        end else if (in_r) begin
            model_ram[sel][addr[7:0]]   = wd;
            model_known[sel][addr[7:0]] = 1'b1;
        end
    endtask

    // One complete access: latency, busy window, error flag and read data.
    task automatic access(input int sel, input logic we, input logic [15:0] addr,
                          input logic [31:0] wd);
        int ws;
        int n;
        ws = (sel != 0) ? 0 : 2;
        drive(sel, 1'b1, we, addr, wd);
        tick();
        drive(sel, 1'b0, 1'b0, 16'h0, 32'h0);
        check("busy_at_accept", 32'(get_busy(sel)), 32'd1);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (get_rdy(sel)) break;
            check("busy_while_wait", 32'(get_busy(sel)), 32'd1);
        end
        check("rdy_latency", n, ws + 1);
        check("busy_in_rdy", 32'(get_busy(sel)), 32'd1);
        check("addr_err", 32'(get_err(sel)), (addr < 16'd256) ? 32'd0 : 32'd1);
        model_apply(sel, we, addr, wd);
        check("rdata", get_rdata(sel), model_rdata[sel]);
        tick();
        check("rdy_drop", 32'(get_rdy(sel)), 32'd0);
        check("busy_drop", 32'(get_busy(sel)), 32'd0);
        check("rdata_hold", get_rdata(sel), model_rdata[sel]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rdy;
        logic [15:0] a;
        logic we;
        int sel;

        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        model_rdata[0] = 32'h0;
        model_rdata[1] = 32'h0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            check("rst_busy", 32'(get_busy(s)), 32'd0);
            check("rst_rdy", 32'(get_rdy(s)), 32'd0);
            check("rst_rdata", get_rdata(s), 32'h0);
            check("rst_err", 32'(get_err(s)), 32'd0);
        end
        rst = 1'b0;

        // Store then load with two wait states
        access(0, 1'b1, 16'h0005, 32'hDEADBEEF);
        access(0, 1'b0, 16'h0005, 32'h0);
        check("load_deadbeef", get_rdata(0), 32'hDEADBEEF);

        // Requests during busy are dropped
        access(0, 1'b1, 16'h0009, 32'h11111111);
        drive(0, 1'b1, 1'b0, 16'h0005, 32'h0);
        tick();
        n_rdy = 0;
        for (int k = 0; k < 8; k++) begin
            if (get_rdy(0) || n_rdy != 0) drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
            else drive(0, 1'b1, 1'b1, 16'h0009, 32'hBAD00BAD);
            tick();
            if (get_rdy(0)) begin
                n_rdy++;
                drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
            end
        end
        model_apply(0, 1'b0, 16'h0005, 32'h0);
        check("one_rdy_per_req", n_rdy, 1);
        check("busy_load_rdata", get_rdata(0), model_rdata[0]);
        access(0, 1'b0, 16'h0009, 32'h0);
        check("ignored_store", get_rdata(0), 32'h11111111);

        // Out-of-range accesses
        access(0, 1'b1, 16'h0000, 32'hCAFE0000);
        access(0, 1'b1, 16'h0100, 32'h12345678);
        access(0, 1'b0, 16'h0000, 32'h0);
        check("oor_no_alias", get_rdata(0), 32'hCAFE0000);
        access(0, 1'b0, 16'h0100, 32'h0);
        check("oor_load_zero", get_rdata(0), 32'h0);

        // Reset in WAIT aborts the store
        access(0, 1'b1, 16'h0003, 32'h0BADF00D);
        drive(0, 1'b1, 1'b1, 16'h0003, 32'hA5A5A5A5);
        tick();
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        tick();
        check("abort_busy_pre", 32'(get_busy(0)), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rdata[0] = 32'h0;
        model_rdata[1] = 32'h0;
        check("abort_busy", 32'(get_busy(0)), 32'd0);
        check("abort_rdy", 32'(get_rdy(0)), 32'd0);
        check("abort_rdata", get_rdata(0), 32'h0);
        n_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (get_rdy(0)) n_rdy++;
        end
        check("abort_no_rdy", n_rdy, 0);
        access(0, 1'b0, 16'h0003, 32'h0);
        check("abort_not_committed", get_rdata(0), 32'h0BADF00D);

        // Zero wait states: held request accepted every other edge
        access(1, 1'b1, 16'h0007, 32'h77770000);
        access(1, 1'b0, 16'h0007, 32'h0);
        drive(1, 1'b1, 1'b0, 16'h0007, 32'h0);
        n_rdy = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 5) drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
            check("held_rdy", 32'(get_rdy(1)), (k % 2 == 1) ? 32'd1 : 32'd0);
            check("held_busy", 32'(get_busy(1)), 32'd1);
            if (get_rdy(1)) n_rdy++;
        end
        check("held_accepts", n_rdy, 3);
        check("held_rdata", get_rdata(1), 32'h77770000);
        tick();
        check("held_idle", 32'(get_busy(1)), 32'd0);

        // Randomized traffic on both units
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(256, 65535));
            else a = 16'($urandom_range(0, 255));
            we = 1'($urandom_range(0, 1));
            if (!we && a < 16'd256 && !model_known[sel][a[7:0]]) we = 1'b1;
            access(sel, we, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
